// File: rtl/pc_pkg.sv
// pc_pkg: shared widths and the fetch-sequencer state type for prog_ctr
package pc_pkg;
    localparam int PC_W     = 10;
    localparam int LUT_AW   = 4;
    localparam int CNT_W    = 16;
    localparam int RS_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: DEPTH-entry LIFO of return addresses for prog_ctr (used only when PC_RETSTACK_EN is defined)
//  Clk, Reset (async, active-low) | clr: empty the stack | push/pop with din/dout (dout = top entry)
//  full/empty flags; a push while full or a pop while empty leaves the stack unchanged
module pc_ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[AW'(cnt - 1'b1)];
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (push && !full) cnt <= cnt + 1'b1;
        else if (pop && !empty) cnt <= cnt - 1'b1;
    always_ff @(posedge Clk)
        if (!clr && push && !full) mem[AW'(cnt)] <= din;
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter / fetch sequencer driving instruction address and LUT_pc index
//  Clk, Reset (async, active-low) | Start+StartAddr begin a run from IDLE or HALTED
//  Stall, Halt, BranchEn, Taken, Imm, Call, Ret: decoded controls | Target: absolute address from LUT_pc
//  LutAddr (=Imm), PC, Running, Done, WrapErr (sticky), InstCnt (saturating), StackErr (sticky)
//  Macro PC_RETSTACK_EN enables the call/return stack; without it Call jumps and Ret increments.
module prog_ctr
    import pc_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic [LUT_AW-1:0] Imm,
    input  logic              Call,
    input  logic              Ret,
    input  logic [PC_W-1:0]   Target,
    output logic [LUT_AW-1:0] LutAddr,
    output logic [PC_W-1:0]   PC,
    output logic              Running,
    output logic              Done,
    output logic              WrapErr,
    output logic [CNT_W-1:0]  InstCnt,
    output logic              StackErr
);
    pc_state_t       state;
    logic            run_adv, take, inc_used, stk_set;
    logic [PC_W-1:0] pc_inc, pc_nxt;
    assign LutAddr = Imm;
    assign Running = state == RUN;
    assign Done    = state == HALTED;
    assign run_adv = (state == RUN) && !Halt && !Stall;
    assign take    = BranchEn && Taken;
    assign pc_inc  = PC + 1'b1;
`ifdef PC_RETSTACK_EN
    logic            full, empty, push, pop, clr;
    logic [PC_W-1:0] top;
    assign clr      = (state != RUN) && Start;
    assign push     = run_adv && !Ret && Call && !full;
    assign pop      = run_adv && Ret && !empty;
    assign stk_set  = run_adv && (Ret ? empty : Call && full);
    assign pc_nxt   = Ret ? (empty ? pc_inc : top) : (Call || take) ? Target : pc_inc;
    assign inc_used = Ret ? empty : !(Call || take);
    pc_ret_stack #(.W(PC_W), .DEPTH(RS_DEPTH)) u_stack (
        .Clk(Clk), .Reset(Reset), .clr(clr), .push(push), .pop(pop),
        .din(pc_inc), .dout(top), .full(full), .empty(empty)
    );
`else
    assign stk_set  = 1'b0;
    assign pc_nxt   = Ret ? pc_inc : (Call || take) ? Target : pc_inc;
    assign inc_used = Ret || !(Call || take);
`endif
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state    <= IDLE;
            PC       <= '0;
            WrapErr  <= 1'b0;
            InstCnt  <= '0;
            StackErr <= 1'b0;
        end else if (state != RUN) begin
            if (Start) begin
                state    <= RUN;
                PC       <= StartAddr;
                InstCnt  <= '0;
                WrapErr  <= 1'b0;
                StackErr <= 1'b0;
            end
        end else begin
            // a halt retires even when stalled in the same cycle
            if (Halt || !Stall) InstCnt <= &InstCnt ? InstCnt : InstCnt + 1'b1;
            if (Halt) state <= HALTED;
            else if (!Stall) begin
                PC <= pc_nxt;
                if (inc_used && &PC) WrapErr <= 1'b1;
                if (stk_set) StackErr <= 1'b1;
            end
        end
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed stimulus for prog_ctr, checked every cycle against a behavioural model plus literal pins
module tb_prog_ctr;
    import pc_pkg::*;
    logic              Clk = 0, Reset = 0, Start = 0, Stall = 0, Halt = 0;
    logic              BranchEn = 0, Taken = 0, Call = 0, Ret = 0;
    logic [PC_W-1:0]   StartAddr = '0, Target = '0, PC;
    logic [LUT_AW-1:0] Imm = '0, LutAddr;
    logic              Running, Done, WrapErr, StackErr;
    logic [CNT_W-1:0]  InstCnt;
    int  n_tests = 0, n_fail = 0;
    bit  chk_en = 0;
    int  m_st = 0, m_pc = 0, m_cnt = 0;
    bit  m_wrap = 0, m_serr = 0;
    int  stk[$];
    always #5 Clk = ~Clk;
    prog_ctr dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
        .Halt(Halt), .BranchEn(BranchEn), .Taken(Taken), .Imm(Imm), .Call(Call), .Ret(Ret),
        .Target(Target), .LutAddr(LutAddr), .PC(PC), .Running(Running), .Done(Done),
        .WrapErr(WrapErr), .InstCnt(InstCnt), .StackErr(StackErr)
    );
    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge Clk);
        #1;
    endtask
    function automatic void m_inc();
        if (m_pc == (1 << PC_W) - 1) begin
            m_pc = 0;
            m_wrap = 1;
        end else m_pc++;
    endfunction
    function automatic void m_retire();
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endfunction
    // model: 0 = idle, 1 = running, 2 = halted
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_st = 0; m_pc = 0; m_cnt = 0; m_wrap = 0; m_serr = 0; stk.delete();
        end else if (m_st != 1) begin
            if (Start) begin
                m_st = 1; m_pc = int'(StartAddr); m_cnt = 0; m_wrap = 0; m_serr = 0; stk.delete();
            end
        end else if (Halt) begin
            m_st = 2;
            m_retire();
        end else if (!Stall) begin
            m_retire();
            if (Ret) begin
`ifdef PC_RETSTACK_EN
                if (stk.size() > 0) m_pc = stk.pop_back();
                else begin
                    m_serr = 1;
                    m_inc();
                end
`else
                m_inc();
`endif
            end else if (Call) begin
`ifdef PC_RETSTACK_EN
                if (stk.size() < RS_DEPTH) stk.push_back((m_pc + 1) % (1 << PC_W));
                else m_serr = 1;
`endif
                m_pc = int'(Target);
            end else if (BranchEn && Taken) m_pc = int'(Target);
            else m_inc();
        end
    end
    always @(negedge Clk)
        if (chk_en) begin
            chk("pc", int'(PC), m_pc);
            chk("running", int'(Running), int'(m_st == 1));
            chk("done", int'(Done), int'(m_st == 2));
            chk("wraperr", int'(WrapErr), int'(m_wrap));
            chk("instcnt", int'(InstCnt), m_cnt);
            chk("stackerr", int'(StackErr), int'(m_serr));
            chk("lutaddr", int'(LutAddr), int'(Imm));
        end
    initial begin
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1;
        chk_en = 1;
        chk("rst_pc", int'(PC), 0);
        chk("rst_running", int'(Running), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_cnt", int'(InstCnt), 0);
        Start = 1; StartAddr = 5; step(); Start = 0;
        chk("start_pc", int'(PC), 5);
        chk("start_running", int'(Running), 1);
        repeat (3) step();
        chk("plain_pc", int'(PC), 8);
        chk("plain_cnt", int'(InstCnt), 3);
        BranchEn = 1; Taken = 1; Imm = 4'b0010; Target = 231;
        #1 chk("lutaddr_lit", int'(LutAddr), 2);
        step();
        chk("branch_pc", int'(PC), 231);
        Taken = 0; step();
        chk("not_taken_pc", int'(PC), 232);
        Taken = 1; Target = 20; step();
        chk("jump20_pc", int'(PC), 20);
        Halt = 1; Stall = 1; Target = 500; step();
        Halt = 0; Stall = 0; BranchEn = 0; Taken = 0;
        chk("halt_pc", int'(PC), 20);
        chk("halt_done", int'(Done), 1);
        chk("halt_cnt", int'(InstCnt), 7);
        BranchEn = 1; Taken = 1; step(); BranchEn = 0; Taken = 0;
        chk("halted_hold_pc", int'(PC), 20);
        Start = 1; StartAddr = 0; step(); Start = 0;
        chk("restart_pc", int'(PC), 0);
        chk("restart_running", int'(Running), 1);
        BranchEn = 1; Taken = 1; Target = 1023; step(); BranchEn = 0; Taken = 0;
        chk("max_pc", int'(PC), 1023);
        step();
        chk("wrap_pc", int'(PC), 0);
        chk("wrap_err", int'(WrapErr), 1);
        Stall = 1; repeat (2) step(); Stall = 0;
        chk("stall_pc", int'(PC), 0);
        chk("stall_cnt", int'(InstCnt), 2);
        step();
        chk("post_stall_pc", int'(PC), 1);
        Start = 1; StartAddr = 77; step(); Start = 0;
        chk("start_in_run_pc", int'(PC), 2);
        chk("wrap_sticky", int'(WrapErr), 1);
        Halt = 1; step(); Halt = 0;
        Start = 1; StartAddr = 37; step(); Start = 0;
        chk("wrap_cleared", int'(WrapErr), 0);
        chk("pc37", int'(PC), 37);
        #2 Reset = 0;
        #1;
        chk("async_rst_pc", int'(PC), 0);
        chk("async_rst_running", int'(Running), 0);
        chk("async_rst_done", int'(Done), 0);
        chk("async_rst_cnt", int'(InstCnt), 0);
        step(); step();
        Reset = 1;
        Start = 1; StartAddr = 10; step(); Start = 0;
        Call = 1; Target = 15; step(); Call = 0;
        chk("call_pc", int'(PC), 15);
        Ret = 1; step(); Ret = 0;
`ifdef PC_RETSTACK_EN
        chk("ret_pc", int'(PC), 11);
        chk("ret_stackerr", int'(StackErr), 0);
        for (int i = 0; i < 5; i++) begin
            Call = 1; Target = PC_W'(100 + 10 * i); step();
        end
        Call = 0;
        chk("nested_pc", int'(PC), 140);
        chk("nested_stackerr", int'(StackErr), 1);
        Ret = 1; repeat (4) step();
        chk("unwind_pc", int'(PC), 12);
        step(); Ret = 0;
        chk("pop_empty_pc", int'(PC), 13);
        Halt = 1; step(); Halt = 0;
        Start = 1; StartAddr = 50; step(); Start = 0;
        chk("stackerr_cleared", int'(StackErr), 0);
        Ret = 1; step(); Ret = 0;
        chk("pop_empty2_pc", int'(PC), 51);
        chk("pop_empty2_err", int'(StackErr), 1);
`else
        chk("ret_pc", int'(PC), 16);
        Call = 1; Ret = 1; Target = 300; step(); Call = 0; Ret = 0;
        chk("ret_over_call_pc", int'(PC), 17);
        chk("stackerr_tied", int'(StackErr), 0);
`endif
        step();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
